// File: rtl/vc_seq_mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   fn_e    : request function encoding (MUL, DIVU, REMU, reserved)
//   state_e : control FSM states (IDLE -> CALC -> DONE -> IDLE)
package vc_seq_mul_div_pkg;

   typedef enum logic [1:0] {
      FnMul  = 2'b00,
      FnDivu = 2'b01,
      FnRemu = 2'b10,
      FnRsvd = 2'b11
   } fn_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StDone = 2'b10
   } state_e;

endpackage

// File: rtl/vc_seq_mul_div_step.sv
// Combinational single-iteration datapath shared by multiply and divide.
// All data ports carry the domain of the request currently in flight.
//   fn             : operation being iterated
//   a, b, acc      : current register values
//   a_next, b_next, acc_next : register values after one iteration
// MUL  : a = multiplicand (shifts left), b = multiplier (shifts right), acc = partial product.
// DIV  : {acc, a} is the {rem, quo} register; a's low bit collects quotient bits while
//        dividend bits leave through its top; b is the divisor and is held.
module vc_seq_mul_div_step
   import vc_seq_mul_div_pkg::*;
#(
   parameter int unsigned p_nbits = 32
) (
   input  fn_e                fn,
   input  logic [p_nbits-1:0] a,
   input  logic [p_nbits-1:0] b,
   input  logic [p_nbits-1:0] acc,
   output logic [p_nbits-1:0] a_next,
   output logic [p_nbits-1:0] b_next,
   output logic [p_nbits-1:0] acc_next
);

   // Remainder after the left shift needs one extra bit; its top bit of the
   // difference doubles as the borrow flag.
   logic [p_nbits:0] shifted;
   logic [p_nbits:0] diff;
   logic             borrow;

   assign shifted = {acc, a[p_nbits-1]};
   assign diff    = shifted - {1'b0, b};
   assign borrow  = diff[p_nbits];

   always_comb begin
      a_next   = a;
      b_next   = b;
      acc_next = acc;
      unique case (fn)
         FnMul: begin
            if (b[0]) begin
               acc_next = acc + a;
            end
            a_next = a << 1;
            b_next = b >> 1;
         end
         FnDivu, FnRemu: begin
            // A zero divisor never borrows, so quo fills with ones and rem ends as a.
            a_next   = {a[p_nbits-2:0], ~borrow};
            acc_next = borrow ? shifted[p_nbits-1:0] : diff[p_nbits-1:0];
         end
         FnRsvd: begin
            // Registers idle; the result mux forces zero. Cycle count is unchanged.
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/vc_seq_mul_div.sv
// Iterative, domain-labelled integer multiply/divide unit, one bit per cycle.
//   clk, reset             : rising-edge clock, asynchronous active-low reset
//   req_val/req_rdy        : request handshake; req_domain labels req_fn/req_a/req_b
//   req_fn                 : 00 MUL, 01 DIVU, 10 REMU, 11 reserved (returns 0)
//   resp_val/resp_rdy      : response handshake
//   resp_domain/resp_data  : latched domain and result, valid only in DONE
// Latency is exactly p_nbits CALC cycles regardless of fn or operands. All
// datapath registers are cleared when the response is taken, so nothing from
// one domain is visible to the next.
module vc_seq_mul_div
   import vc_seq_mul_div_pkg::*;
#(
   parameter int unsigned p_nbits     = 32,
   parameter int unsigned p_cnt_nbits = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic               req_domain,
   input  logic [1:0]         req_fn,
   input  logic [p_nbits-1:0] req_a,
   input  logic [p_nbits-1:0] req_b,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic               resp_domain,
   output logic [p_nbits-1:0] resp_data
);

   localparam logic [p_cnt_nbits-1:0] LastCnt = p_cnt_nbits'(p_nbits - 1);

   state_e                   state_q, state_d;
   logic [p_cnt_nbits-1:0]   cnt_q, cnt_d;
   logic [p_nbits-1:0]       a_q, a_d;
   logic [p_nbits-1:0]       b_q, b_d;
   logic [p_nbits-1:0]       acc_q, acc_d;
   fn_e                      fn_q, fn_d;
   logic                     domain_q, domain_d;

   logic [p_nbits-1:0]       a_step, b_step, acc_step;
   logic [p_nbits-1:0]       result;

   vc_seq_mul_div_step #(
      .p_nbits (p_nbits)
   ) u_step (
      .fn       (fn_q),
      .a        (a_q),
      .b        (b_q),
      .acc      (acc_q),
      .a_next   (a_step),
      .b_next   (b_step),
      .acc_next (acc_step)
   );

   // Result selection reads registers only; no path from req_* reaches resp_*.
   always_comb begin
      result = '0;
      unique case (fn_q)
         FnMul:   result = acc_q;
         FnDivu:  result = a_q;
         FnRemu:  result = acc_q;
         FnRsvd:  result = '0;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         fn_q     <= FnMul;
         domain_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         fn_q     <= fn_d;
         domain_q <= domain_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      fn_d        = fn_q;
      domain_d    = domain_q;
      req_rdy     = 1'b0;
      resp_val    = 1'b0;
      resp_domain = 1'b0;
      resp_data   = '0;

      unique case (state_q)
         StIdle: begin
            req_rdy = 1'b1;
            if (req_val) begin
               a_d      = req_a;
               b_d      = req_b;
               fn_d     = fn_e'(req_fn);
               domain_d = req_domain;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = StCalc;
            end
         end
         StCalc: begin
            a_d   = a_step;
            b_d   = b_step;
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            resp_val    = 1'b1;
            resp_domain = domain_q;
            resp_data   = result;
            if (resp_rdy) begin
               // Scrub so the next domain observes nothing of this one.
               a_d      = '0;
               b_d      = '0;
               acc_d    = '0;
               fn_d     = FnMul;
               domain_d = 1'b0;
               cnt_d    = '0;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule
